// File: rtl/game_pkg.sv
// game_pkg: shared types and constants for the game event front-end.
//   deb_state_e           debounce FSM states
//   DEBOUNCE_CYCLES_100M  5 ms of clock at 100 MHz
//   FRAME_CYCLES_100M     one 60 Hz frame at 100 MHz
//   AUTOREPEAT_FRAMES     screen ticks between auto-repeat presses
package game_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    PRESSED      = 2'd2,
    RELEASE_WAIT = 2'd3
  } deb_state_e;

  localparam int DEBOUNCE_CYCLES_100M = 500000;
  localparam int FRAME_CYCLES_100M    = 1666667;
  localparam int AUTOREPEAT_FRAMES    = 8;

endpackage

// File: rtl/game_event_ctrl_if.sv
// game_event_ctrl_if: software-facing side of the event front-end.
//   ack_button/ack_screen/ack_collision  one-cycle clear strobes (host -> ctrl)
//   button_signal/screen_signal/collision_signal  sticky event flags (ctrl -> host)
//   button_level   current debounced button level
//   overrun_count  frame ticks lost while screen_signal was pending
// Modports: master = host/register file, slave = game_event_ctrl.
interface game_event_ctrl_if #(
  parameter int OVR_W = 8
);
  logic             ack_button;
  logic             ack_screen;
  logic             ack_collision;
  logic             button_signal;
  logic             screen_signal;
  logic             collision_signal;
  logic             button_level;
  logic [OVR_W-1:0] overrun_count;

  modport master (
    output ack_button, ack_screen, ack_collision,
    input  button_signal, screen_signal, collision_signal, button_level, overrun_count
  );

  modport slave (
    input  ack_button, ack_screen, ack_collision,
    output button_signal, screen_signal, collision_signal, button_level, overrun_count
  );
endinterface

// File: rtl/game_event_ctrl_sticky_flag.sv
// sticky_flag: event flag held until acknowledged.
//   clock, reset (async, active-low)
//   set   single-cycle event pulse
//   ack   single-cycle clear strobe
//   flag  sticky output; a set in the same cycle as ack wins
module sticky_flag (
  input  logic clock,
  input  logic reset,
  input  logic set,
  input  logic ack,
  output logic flag
);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      flag <= 1'b0;
    end else if (set) begin
      flag <= 1'b1;
    end else if (ack) begin
      flag <= 1'b0;
    end
  end

endmodule

// File: rtl/game_event_ctrl.sv
// game_event_ctrl: debounces the jump button, edge-detects collisions and
// generates the frame tick; each event latches into a sticky flag that
// software clears with an ack strobe.
//   clock          system clock
//   reset          asynchronous active-low reset
//   button_raw     asynchronous jump-button pin
//   collision_raw  asynchronous collision level
//   bus            game_event_ctrl_if.slave (acks in; flags, level, overrun out)
// Build option: GAME_EVT_AUTOREPEAT_EN adds a repeat press every
// AUTOREPEAT_FRAMES screen ticks while the button is held.
module game_event_ctrl
  import game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_100M,
  parameter int FRAME_CYCLES    = FRAME_CYCLES_100M,
  parameter int CNT_W           = 21,
  parameter int OVR_W           = 8
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             button_raw,
  input  logic             collision_raw,
  game_event_ctrl_if.slave bus
);

  logic b_meta, b_sync;
  logic c_meta, c_sync, c_prev;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      b_meta <= 1'b0;
      b_sync <= 1'b0;
      c_meta <= 1'b0;
      c_sync <= 1'b0;
      c_prev <= 1'b0;
    end else begin
      b_meta <= button_raw;
      b_sync <= b_meta;
      c_meta <= collision_raw;
      c_sync <= c_meta;
      c_prev <= c_sync;
    end
  end

  // Debounce: the counter is cleared on entry to a wait state, so a level
  // must be seen DEBOUNCE_CYCLES+1 consecutive cycles to be accepted.
  deb_state_e       state;
  logic [CNT_W-1:0] deb_cnt;
  logic             deb_done;
  logic             press_evt_deb;
  logic             press_evt;

  assign deb_done = (deb_cnt == CNT_W'(DEBOUNCE_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      deb_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (b_sync) begin
            state   <= PRESS_WAIT;
            deb_cnt <= '0;
          end
        end
        PRESS_WAIT: begin
          if (!b_sync)       state   <= IDLE;
          else if (deb_done) state   <= PRESSED;
          else               deb_cnt <= deb_cnt + CNT_W'(1);
        end
        PRESSED: begin
          if (!b_sync) begin
            state   <= RELEASE_WAIT;
            deb_cnt <= '0;
          end
        end
        RELEASE_WAIT: begin
          if (b_sync)        state   <= PRESSED;
          else if (deb_done) state   <= IDLE;
          else               deb_cnt <= deb_cnt + CNT_W'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign press_evt_deb    = (state == PRESS_WAIT) && b_sync && deb_done;
  // Level holds through RELEASE_WAIT so a bouncing release does not drop it.
  assign bus.button_level = (state == PRESSED) || (state == RELEASE_WAIT);

  logic [CNT_W-1:0] frame_cnt;
  logic             frame_evt;

  assign frame_evt = (frame_cnt == CNT_W'(FRAME_CYCLES - 1));

  always_ff @(posedge clock or negedge reset) begin
    if (!reset)         frame_cnt <= '0;
    else if (frame_evt) frame_cnt <= '0;
    else                frame_cnt <= frame_cnt + CNT_W'(1);
  end

`ifdef GAME_EVT_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(AUTOREPEAT_FRAMES);

  logic [RPT_W-1:0] rpt_cnt;
  logic             rpt_evt;

  assign rpt_evt = (state == PRESSED) && frame_evt &&
                   (rpt_cnt == RPT_W'(AUTOREPEAT_FRAMES - 1));

  // Held at zero outside PRESSED, so every entry into PRESSED restarts the count.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset)                rpt_cnt <= '0;
    else if (state != PRESSED) rpt_cnt <= '0;
    else if (rpt_evt)          rpt_cnt <= '0;
    else if (frame_evt)        rpt_cnt <= rpt_cnt + RPT_W'(1);
  end

  assign press_evt = press_evt_deb | rpt_evt;
`else
  assign press_evt = press_evt_deb;
`endif

  logic [OVR_W-1:0] ovr_cnt;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      ovr_cnt <= '0;
    end else if (frame_evt && bus.screen_signal && !bus.ack_screen && (ovr_cnt != '1)) begin
      ovr_cnt <= ovr_cnt + OVR_W'(1);
    end
  end

  assign bus.overrun_count = ovr_cnt;

  sticky_flag u_button_flag (
    .clock (clock),
    .reset (reset),
    .set   (press_evt),
    .ack   (bus.ack_button),
    .flag  (bus.button_signal)
  );

  sticky_flag u_screen_flag (
    .clock (clock),
    .reset (reset),
    .set   (frame_evt),
    .ack   (bus.ack_screen),
    .flag  (bus.screen_signal)
  );

  sticky_flag u_collision_flag (
    .clock (clock),
    .reset (reset),
    .set   (c_sync & ~c_prev),
    .ack   (bus.ack_collision),
    .flag  (bus.collision_signal)
  );

endmodule

// File: tb/tb_game_event_ctrl.sv
// tb_game_event_ctrl: directed scenarios plus random pin/ack traffic for
// game_event_ctrl, compared every cycle against a run-length reference model.
module tb_game_event_ctrl;

  localparam int D = 4;
  localparam int F = 10;

  logic clock = 1'b0;
  logic reset = 1'b0;
  logic button_raw = 1'b0;
  logic collision_raw = 1'b0;

  game_event_ctrl_if #(.OVR_W(8)) bus ();

  game_event_ctrl #(
    .DEBOUNCE_CYCLES (D),
    .FRAME_CYCLES    (F),
    .CNT_W           (8),
    .OVR_W           (8)
  ) dut (
    .clock         (clock),
    .reset         (reset),
    .button_raw    (button_raw),
    .collision_raw (collision_raw),
    .bus           (bus)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // Reference model: pins reach the logic two edges late; the debounced
  // level flips once the delayed pin has disagreed with it for D+1 edges.
  logic       bp1, bp2, cp1, cp2, c_last;
  logic       m_level, m_bflag, m_sflag, m_cflag;
  logic [7:0] m_ovr;
  int         opp;
  int         fcnt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s at %0t: observed %0h expected %0h", tag, $time, obs, exp);
    end
  endtask

  task automatic model_clear();
    bp1 = 0; bp2 = 0; cp1 = 0; cp2 = 0; c_last = 0;
    m_level = 0; m_bflag = 0; m_sflag = 0; m_cflag = 0;
    m_ovr = 0; opp = 0; fcnt = 0;
  endtask

  task automatic check_all();
    chk("button_signal",    32'(bus.button_signal),    32'(m_bflag));
    chk("button_level",     32'(bus.button_level),     32'(m_level));
    chk("screen_signal",    32'(bus.screen_signal),    32'(m_sflag));
    chk("collision_signal", 32'(bus.collision_signal), 32'(m_cflag));
    chk("overrun_count",    32'(bus.overrun_count),    32'(m_ovr));
  endtask

  task automatic tick();
    logic sb, sc, pe, ce, fe;
    if (!reset) begin
      model_clear();
    end else begin
      sb = bp2;
      sc = cp2;
      pe = 1'b0;
      if (sb != m_level) begin
        opp++;
        if (opp == D + 1) begin
          m_level = sb;
          opp     = 0;
          pe      = sb;
        end
      end else begin
        opp = 0;
      end
      ce     = sc && !c_last;
      c_last = sc;
      bp2 = bp1; bp1 = button_raw;
      cp2 = cp1; cp1 = collision_raw;
      fcnt++;
      fe = ((fcnt % F) == 0);
      if (fe && m_sflag && !bus.ack_screen && m_ovr != 8'hff) m_ovr++;
      m_sflag = fe || (m_sflag && !bus.ack_screen);
      m_bflag = pe || (m_bflag && !bus.ack_button);
      m_cflag = ce || (m_cflag && !bus.ack_collision);
    end
    @(posedge clock);
    #1;
    check_all();
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    #1;
    check_all();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    int rise;
    bus.ack_button    = 1'b0;
    bus.ack_screen    = 1'b0;
    bus.ack_collision = 1'b0;
    model_clear();
    #1;
    check_all();
    tick();

    // Reset in the middle of a held press, then latency from release.
    reset = 1'b1;
    button_raw = 1'b1;
    repeat (5) tick();
    reset = 1'b0;
    model_clear();
    #1;
    chk("async_reset_level", 32'(bus.button_level), 32'd0);
    check_all();
    repeat (2) tick();
    reset = 1'b1;
    rise = 0;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (bus.button_signal === 1'b1 && rise == 0) rise = i;
    end
    chk("press_latency", 32'(rise), 32'd7);

    // Bounce: pulses of 1, 2, 3 cycles with 2-cycle gaps.
    button_raw = 1'b0;
    do_reset();
    for (int l = 1; l <= 3; l++) begin
      button_raw = 1'b1;
      repeat (l) tick();
      button_raw = 1'b0;
      repeat (2) tick();
    end
    repeat (8) tick();
    chk("bounce_flag",  32'(bus.button_signal), 32'd0);
    chk("bounce_level", 32'(bus.button_level),  32'd0);

    // Sticky flag survives a second press; ack clears it.
    button_raw = 1'b1; repeat (8) tick();
    chk("first_press", 32'(bus.button_signal), 32'd1);
    button_raw = 1'b0; repeat (8) tick();
    button_raw = 1'b1; repeat (8) tick();
    chk("second_press_sticky", 32'(bus.button_signal), 32'd1);
    bus.ack_button = 1'b1; tick();
    bus.ack_button = 1'b0;
    chk("ack_clears", 32'(bus.button_signal), 32'd0);
    button_raw = 1'b0; repeat (8) tick();

    // Ack in the exact cycle of the frame wrap: set wins.
    bus.ack_screen = 1'b1;
    repeat (2) tick();
    while (((fcnt + 1) % F) != 0) tick();
    chk("pre_wrap_cleared", 32'(bus.screen_signal), 32'd0);
    tick();
    chk("set_wins", 32'(bus.screen_signal), 32'd1);
    bus.ack_screen = 1'b0;

    // Overrun counting and saturation.
    do_reset();
    repeat (50) tick();
    chk("overrun_flag", 32'(bus.screen_signal), 32'd1);
    chk("overrun_5",    32'(bus.overrun_count), 32'd4);
    repeat (3000) tick();
    chk("overrun_sat",  32'(bus.overrun_count), 32'd255);

    // Collision: one event per rising edge.
    collision_raw = 1'b1;
    repeat (4) tick();
    chk("coll_first", 32'(bus.collision_signal), 32'd1);
    bus.ack_collision = 1'b1; tick();
    bus.ack_collision = 1'b0;
    repeat (25) tick();
    chk("coll_held_once", 32'(bus.collision_signal), 32'd0);
    collision_raw = 1'b0; repeat (3) tick();
    collision_raw = 1'b1; repeat (4) tick();
    chk("coll_second_edge", 32'(bus.collision_signal), 32'd1);
    collision_raw = 1'b0;

    // Random pin activity and acks.
    do_reset();
    for (int i = 0; i < 1500; i++) begin
      if ($urandom_range(0, 9) == 0) button_raw = ~button_raw;
      if ($urandom_range(0, 6) == 0) collision_raw = ~collision_raw;
      bus.ack_button    = ($urandom_range(0, 3) == 0);
      bus.ack_screen    = ($urandom_range(0, 3) == 0);
      bus.ack_collision = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/game_event_ctrl.md
Name: game_event_ctrl

Overview:
- Upstream front-end for the dino processor wrapper.
- Turns the raw jump-button pin and the raw collision pin from the sprite-overlap logic into clean, sticky event flags, and generates the per-frame screen tick.
- Its outputs drive the wrapper's button_signal, collision_signal and screen_signal, which the register file exposes to game software.
- Software clears each flag with a one-cycle acknowledge strobe, so no event is lost between polls.

Parameters:
- DEBOUNCE_CYCLES, 500000, cycles a synchronized button level must stay stable before it is accepted (5 ms at 100 MHz).
- FRAME_CYCLES, 1666667, clock cycles per screen tick (60 Hz at 100 MHz).
- CNT_W, 21, width of the debounce and frame counters; must hold max(DEBOUNCE_CYCLES, FRAME_CYCLES)-1.
- OVR_W, 8, width of the frame-overrun counter.

Ports:
- clock  in  1  system clock, all state on rising edge.
- reset  in  1  asynchronous, active-low reset.
- button_raw  in  1  asynchronous jump-button pin.
- collision_raw  in  1  asynchronous collision level from overlap logic.
- ack_button  in  1  one-cycle strobe that clears button_signal.
- ack_screen  in  1  one-cycle strobe that clears screen_signal.
- ack_collision  in  1  one-cycle strobe that clears collision_signal.
- button_signal  out  1  sticky flag: a debounced press occurred.
- screen_signal  out  1  sticky flag: a frame tick occurred.
- collision_signal  out  1  sticky flag: a collision rising edge occurred.
- button_level  out  1  current debounced button level.
- overrun_count  out  OVR_W  frame ticks that arrived while screen_signal was already set.

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, all counters 0, synchronizer flops 0, FSM in IDLE.
- Synchronization: button_raw and collision_raw each pass through a 2-flop synchronizer. Synchronized values lag the pins by 2 cycles.
- Debounce FSM, driven by synchronized button sb:
  - IDLE (button_level=0): sb=1 -> PRESS_WAIT, debounce counter cleared.
  - PRESS_WAIT: sb=0 -> IDLE. Counter reaching DEBOUNCE_CYCLES-1 with sb=1 -> PRESSED, and a press event fires this cycle.
  - PRESSED (button_level=1): sb=0 -> RELEASE_WAIT, counter cleared.
  - RELEASE_WAIT: sb=1 -> PRESSED. Counter reaching DEBOUNCE_CYCLES-1 with sb=0 -> IDLE.
  - A glitch shorter than DEBOUNCE_CYCLES produces no event.
- Latency: pin rise to button_signal=1 is 2 + DEBOUNCE_CYCLES + 1 cycles.
- Collision: an event fires on a 0->1 edge of the synchronized collision level. A level held high produces only one event.
- Frame counter:
  - Counts 0..FRAME_CYCLES-1 and wraps to 0.
  - At wrap, a screen event fires.
  - Runs freely from reset release; first event occurs at cycle FRAME_CYCLES after reset release.
- Sticky flags: an event sets the flag; ack clears it on the next edge. An event and ack in the same cycle leave the flag set (set wins). An ack while the flag is clear has no effect.
- Overrun: a screen event while screen_signal=1 and ack_screen=0 increments overrun_count, saturating at all-ones. overrun_count is cleared only by reset.
- Events are single-cycle internal pulses; there is no queuing beyond one pending flag per source.

Optional Feature:
- GAME_EVT_AUTOREPEAT_EN defined: while in PRESSED, the button fires an additional press event on every 8th screen event. The repeat count restarts each time PRESSED is entered.
- Macro not defined: exactly one press event per debounced press; the repeat counter logic is absent.

Decomposition:
- Shared package game_pkg holds:
  - the debounce state enum (IDLE, PRESS_WAIT, PRESSED, RELEASE_WAIT);
  - default timing constants DEBOUNCE_CYCLES_100M and FRAME_CYCLES_100M;
  - the AUTOREPEAT_FRAMES constant (8).
- One natural sub-module, sticky_flag: holds set/ack/flag with set-wins priority. It is instantiated three times.
- The synchronizers and the frame counter stay inline.

Test Plan (DEBOUNCE_CYCLES=4, FRAME_CYCLES=10):
- Reset mid-press: hold button_raw=1 for 20 cycles, pull reset low at cycle 5 -> all outputs 0 immediately; after release, button_signal rises at cycle 7 (2+4+1).
- Bounce: button_raw pulses of 1,2,3 cycles separated by gaps of 2 cycles -> button_signal stays 0 and button_level stays 0.
- Sticky and ack: a valid press sets button_signal=1; a second press before ack leaves it at 1; ack_button pulse -> 0 next cycle.
- Set-wins: ack_screen asserted in the exact cycle of the frame wrap -> screen_signal stays 1.
- Overrun: no acks for 5 frames (50 cycles) -> screen_signal=1, overrun_count=4. Forcing 300 unacked frames -> overrun_count=255.
- Collision: collision_raw held high for 30 cycles -> exactly one collision_signal set. Ack, then a second rising edge -> set again.
